sigmoid_arbiter: RTL



---
 rtl/sigmoid_arbiter.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/sigmoid_arbiter.sv
// -----------------------------------------------------------------------------
// sigmoid_arbiter
//
// Shares one combinational Q4.12 sigmoid unit among NUM_REQ requesters.
// Requesters are served round-robin. The winning operand is registered onto
// sig_x. The block then waits SIG_LAT cycles for the sigmoid to settle,
// captures sig_y and returns it with the requester index on a valid/ready
// response channel.
//
// Ports:
//   clk        clock, all logic on the rising edge
//   rst_n      synchronous active-low reset
//   req_valid  per-requester request valid            [NUM_REQ]
//   req_x      packed operands, requester i at [i*DATA_W +: DATA_W]
//   req_ready  one-hot grant/accept (combinational, IDLE only)
//   sig_x      registered operand to the shared sigmoid
//   sig_y      sigmoid result
//   rsp_valid  response valid
//   rsp_y      registered result
//   rsp_id     index of the requester that owns rsp_y
//   rsp_ready  consumer accepts the response
//   busy       high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module sigmoid_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 16,
    parameter int ID_W    = 2,
    parameter int SIG_LAT = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_x,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [DATA_W-1:0]         sig_x,
    input  logic [DATA_W-1:0]         sig_y,
    output logic                      rsp_valid,
    output logic [DATA_W-1:0]         rsp_y,
    output logic [ID_W-1:0]           rsp_id,
    input  logic                      rsp_ready,
    output logic                      busy
);

    // SIG_LAT is limited to 1..15, so the settle counter fits in 4 bits.
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [ID_W-1:0]     rr_ptr_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [DATA_W-1:0]   sig_x_r;
    logic [DATA_W-1:0]   rsp_y_r;
    logic [ID_W-1:0]     rsp_id_r;
    logic                rsp_valid_r;
    logic                busy_r;

    logic [NUM_REQ-1:0]  grant_s;
    logic [ID_W-1:0]     grant_idx_s;
    logic                grant_found_s;
    logic [ID_W-1:0]     next_ptr_s;
    logic [DATA_W-1:0]   grant_x_s;

    // Round-robin search: first valid requester at or after rr_ptr, with wrap.
    always_comb begin
        int              idx_v;
        logic [ID_W-1:0] idx_b;
        idx_v         = 0;
        idx_b         = '0;
        grant_s       = '0;
        grant_idx_s   = '0;
        grant_found_s = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_v = int'(rr_ptr_r) + k;
            if (idx_v >= NUM_REQ) begin
                idx_v = idx_v - NUM_REQ;
            end else begin
                idx_v = idx_v;
            end
            idx_b = ID_W'(idx_v);
            if (!grant_found_s && req_valid[idx_b]) begin
                grant_found_s  = 1'b1;
                grant_s[idx_b] = 1'b1;
                grant_idx_s    = idx_b;
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // Pointer that follows the winner, plus the winner's operand.
    always_comb begin
        if (grant_idx_s == ID_W'(NUM_REQ - 1)) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = grant_idx_s + ID_W'(1);
        end
        grant_x_s = req_x[int'(grant_idx_s)*DATA_W +: DATA_W];
    end

    // Grants are only offered while IDLE.
    always_comb begin
        if (state_r == IDLE) begin
            req_ready = grant_s;
        end else begin
            req_ready = '0;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (grant_found_s) begin
                    state_nxt_s = EVAL;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            EVAL: begin
                if (cnt_r == '0) begin
                    state_nxt_s = RESP;
                end else begin
                    state_nxt_s = EVAL;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register; busy is registered from the next state so it tracks state_r.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s != IDLE);
        end
    end

    // Datapath: operand capture, settle counter and response registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_r    <= '0;
            cnt_r       <= '0;
            sig_x_r     <= '0;
            rsp_y_r     <= '0;
            rsp_id_r    <= '0;
            rsp_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_found_s) begin
                        sig_x_r  <= grant_x_s;
                        rsp_id_r <= grant_idx_s;
                        rr_ptr_r <= next_ptr_s;
                        cnt_r    <= CNT_W'(SIG_LAT - 1);
                    end
                end
                EVAL: begin
                    // sig_y is sampled only on the last settle cycle.
                    if (cnt_r != '0) begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end else begin
                        rsp_y_r     <= sig_y;
                        rsp_valid_r <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                    end
                end
                default: begin
                    rsp_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign sig_x     = sig_x_r;
    assign rsp_y     = rsp_y_r;
    assign rsp_id    = rsp_id_r;
    assign rsp_valid = rsp_valid_r;
    assign busy      = busy_r;

endmodule
